// File: rtl/bus_datapath_pkg.sv
// Shared types for the sequenced single-bus datapath: opcodes, sequencer states, opcode width.
package bus_datapath_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_MUL = 3'd6,
    OP_MOV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADY = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MUL   = 3'd3,
    ST_WB    = 3'd4
  } state_e;

endpackage

// File: rtl/bus_datapath_seq_if.sv
// Control/observation bundle between the future control unit (master) and the datapath (slave).
interface bus_datapath_seq_if
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) ();
  localparam int REG_AW = $clog2(NUM_REGS);

  logic              start;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rd;
  logic              ext_we;
  logic [REG_AW-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] bus_out;

  modport master (
    output start, op, ra, rb, rd, ext_we, ext_addr, ext_data, dbg_addr,
    input  dbg_data, busy, done, hi, lo, bus_out
  );

  modport slave (
    input  start, op, ra, rb, rd, ext_we, ext_addr, ext_data, dbg_addr,
    output dbg_data, busy, done, hi, lo, bus_out
  );
endinterface

// File: rtl/bus_datapath_seq_alu.sv
// Combinational single-cycle ALU (dp_alu); MUL is iterated by the sequencer and yields 0 here.
module dp_alu
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);
  localparam int SHW = $clog2(DATA_W);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_SHL:  res_o = a_i << b_i[SHW-1:0];
      OP_SHR:  res_o = a_i >> b_i[SHW-1:0];
      OP_MOV:  res_o = b_i;
      default: res_o = '0;
    endcase
  end
endmodule

// File: rtl/bus_datapath_seq.sv
// Register file + Y/Z/HI/LO staging with a T-state sequencer, one operation per start pulse.
// Optional feature macro: ZERO_REG_EN (R0 hardwired to zero).
//   state    | meaning
//   ST_IDLE  | accept start / external loads
//   ST_LOADY | bus = R[ra], Y <= bus
//   ST_EXEC  | bus = R[rb], Z <= ALU(Y,bus) or seed multiplier
//   ST_MUL   | one shift-add step per cycle, down-counter to 1
//   ST_WB    | bus = Zlow, R[rd] <= bus, MUL also loads HI/LO
module bus_datapath_seq
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic              clock,
  input logic              clear,
  bus_datapath_seq_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(DATA_W) + 1;
`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_e              state_q;
  op_e                 op_q;
  logic [REG_AW-1:0]   ra_q, rb_q, rd_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   y_q, hi_q, lo_q;
  logic [2*DATA_W-1:0] z_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;

  logic [DATA_W-1:0]   bus_d;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W:0]     mul_sum;

  function automatic logic [DATA_W-1:0] reg_rd(input logic [REG_AW-1:0] addr);
    if (ZERO_REG && addr == '0) return '0;
    return regs_q[addr];
  endfunction

  function automatic logic wr_ok(input logic [REG_AW-1:0] addr);
    return (addr != '0) || !ZERO_REG;
  endfunction

  always_comb begin
    bus_d = '0;
    case (state_q)
      ST_LOADY: bus_d = reg_rd(ra_q);
      ST_EXEC:  bus_d = reg_rd(rb_q);
      ST_WB:    bus_d = z_q[DATA_W-1:0];
      default:  bus_d = '0;
    endcase
  end

  // Z holds {acc, multiplier}; acc gains Y when the multiplier LSB is set, then the pair shifts right.
  assign mul_sum = {1'b0, z_q[2*DATA_W-1:DATA_W]} + (z_q[0] ? {1'b0, y_q} : '0);

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (op_q),
    .a_i   (y_q),
    .b_i   (bus_d),
    .res_o (alu_res)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.ext_we && wr_ok(bus.ext_addr)) regs_q[bus.ext_addr] <= bus.ext_data;
          if (bus.start) begin
            op_q    <= op_e'(bus.op);
            ra_q    <= bus.ra;
            rb_q    <= bus.rb;
            rd_q    <= bus.rd;
            state_q <= ST_LOADY;
          end
        end
        ST_LOADY: begin
          y_q     <= bus_d;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_q == OP_MUL) begin
            z_q     <= {{DATA_W{1'b0}}, bus_d};
            cnt_q   <= CNT_W'(DATA_W);
            state_q <= ST_MUL;
          end else begin
            z_q     <= {{DATA_W{1'b0}}, alu_res};
            state_q <= ST_WB;
          end
        end
        ST_MUL: begin
          z_q   <= {mul_sum, z_q[DATA_W-1:1]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ST_WB;
        end
        ST_WB: begin
          if (wr_ok(rd_q)) regs_q[rd_q] <= bus_d;
          if (op_q == OP_MUL) {hi_q, lo_q} <= z_q;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.dbg_data = reg_rd(bus.dbg_addr);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.bus_out  = bus_d;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Self-checking bench for bus_datapath_seq: directed scenarios plus random ops against an arithmetic model.
module tb_bus_datapath_seq;
  logic clk;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] model_r [16];
  logic [31:0] model_hi, model_lo;

  bus_datapath_seq_if #(.DATA_W(32), .NUM_REGS(16)) dif ();

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mr(input logic [3:0] a);
`ifdef ZERO_REG_EN
    if (a == 4'd0) return 32'd0;
`endif
    return model_r[a];
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] v);
`ifdef ZERO_REG_EN
    if (a == 4'd0) return;
`endif
    model_r[a] = v;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_r[i] = 32'd0;
    model_hi = 32'd0;
    model_lo = 32'd0;
  endtask

  task automatic ext_write(input logic [3:0] a, input logic [31:0] v);
    dif.ext_we = 1'b1; dif.ext_addr = a; dif.ext_data = v;
    @(negedge clk);
    dif.ext_we = 1'b0;
    model_write(a, v);
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
    dif.dbg_addr = a;
    #1;
    n_checks++;
    if (dif.dbg_data !== exp) begin
      n_fail++;
      $display("FAIL %s R%0d: got %h expected %h", name, a, dif.dbg_data, exp);
    end
  endtask

  // Launches one op from a negedge, follows it to done, and checks timing, bus and results.
  task automatic run_op(input string name, input logic [2:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] d);
    logic [31:0] va, vb, exp;
    logic [63:0] prod;
    int k, busy_n, exp_lat;
    bit seen;
    va = mr(a); vb = mr(b); prod = 64'd0;
    case (o)
      3'd0: exp = va + vb;
      3'd1: exp = va - vb;
      3'd2: exp = va & vb;
      3'd3: exp = va | vb;
      3'd4: exp = va << (vb % 32);
      3'd5: exp = va >> (vb % 32);
      3'd6: begin prod = {32'd0, va} * {32'd0, vb}; exp = prod[31:0]; end
      default: exp = vb;
    endcase
    exp_lat = (o == 3'd6) ? 35 : 3;
    dif.start = 1'b1; dif.op = o; dif.ra = a; dif.rb = b; dif.rd = d;
    @(negedge clk);
    dif.start = 1'b0;
    k = 0; busy_n = 0; seen = 0;
    while (k < 60 && !seen) begin
      if (k == 0) begin
        n_checks++;
        if (dif.bus_out !== va) begin n_fail++; $display("FAIL %s bus_loady: got %h expected %h", name, dif.bus_out, va); end
      end
      if (k == 1) begin
        n_checks++;
        if (dif.bus_out !== vb) begin n_fail++; $display("FAIL %s bus_exec: got %h expected %h", name, dif.bus_out, vb); end
      end
      if (dif.done === 1'b1) seen = 1;
      else begin
        if (dif.busy === 1'b1) busy_n++;
        @(negedge clk);
        k++;
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL %s timeout: no done within %0d cycles", name, k); end
    n_checks++;
    if (k != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat); end
    n_checks++;
    if (busy_n != exp_lat) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_lat); end
    n_checks++;
    if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_with_done: got %b expected 0", name, dif.busy); end
    model_write(d, exp);
    if (o == 3'd6) begin model_hi = prod[63:32]; model_lo = prod[31:0]; end
    n_checks++;
    if (dif.hi !== model_hi || dif.lo !== model_lo) begin
      n_fail++;
      $display("FAIL %s hilo: got %h_%h expected %h_%h", name, dif.hi, dif.lo, model_hi, model_lo);
    end
    check_reg(name, d, mr(d));
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    n_checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.bus_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b done=%b bus=%h expected 0 0 0", dif.busy, dif.done, dif.bus_out);
    end
    for (int i = 0; i < 16; i++) check_reg("reset", 4'(i), 32'd0);
    clear = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_basic();
    ext_write(4'd1, 32'd7);
    ext_write(4'd2, 32'd5);
    run_op("add", 3'd0, 4'd1, 4'd2, 4'd3);
    n_checks++;
    if (model_r[3] !== 32'd12) begin n_fail++; $display("FAIL add_const: got %h expected %h", model_r[3], 32'd12); end
    ext_write(4'd1, 32'd0);
    ext_write(4'd2, 32'd1);
    run_op("sub_wrap", 3'd1, 4'd1, 4'd2, 4'd3);
    check_reg("sub_wrap_abs", 4'd3, 32'hFFFF_FFFF);
    ext_write(4'd1, 32'd1);
    ext_write(4'd2, 32'd35);
    run_op("shl_mod", 3'd4, 4'd1, 4'd2, 4'd3);
    check_reg("shl_mod_abs", 4'd3, 32'd8);
  endtask

  task automatic test_mul();
    ext_write(4'd1, 32'hFFFF_FFFF);
    ext_write(4'd2, 32'd2);
    run_op("mul", 3'd6, 4'd1, 4'd2, 4'd3);
    n_checks++;
    if (dif.hi !== 32'd1 || dif.lo !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL mul_abs: got %h_%h expected 00000001_fffffffe", dif.hi, dif.lo);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    ext_write(4'd1, 32'd3);
    ext_write(4'd2, 32'd9);
    dif.start = 1'b1; dif.op = 3'd6; dif.ra = 4'd1; dif.rb = 4'd2; dif.rd = 4'd5;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.op = 3'd0; dif.ext_we = 1'b1; dif.ext_addr = 4'd1; dif.ext_data = 32'hDEAD_BEEF;
    @(negedge clk);
    dif.start = 1'b0; dif.ext_we = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      if (dif.done === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL busy_ignore_dones: got %0d expected 1", dones); end
    model_write(4'd5, 32'd27);
    model_hi = 32'd0; model_lo = 32'd27;
    check_reg("busy_ignore_r1", 4'd1, mr(4'd1));
    check_reg("busy_ignore_r5", 4'd5, mr(4'd5));
  endtask

  task automatic test_same_cycle();
    ext_write(4'd2, 32'd4);
    dif.ext_we = 1'b1; dif.ext_addr = 4'd1; dif.ext_data = 32'd100;
    model_write(4'd1, 32'd100);
    run_op("same_cycle", 3'd0, 4'd1, 4'd2, 4'd6);
    dif.ext_we = 1'b0;
    check_reg("same_cycle_abs", 4'd6, 32'd104);
  endtask

  task automatic test_clear_mid();
    dif.start = 1'b1; dif.op = 3'd6; dif.ra = 4'd1; dif.rb = 4'd2; dif.rd = 4'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (12) @(negedge clk);
    #2 clear = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.hi !== 32'd0 || dif.lo !== 32'd0 || dif.bus_out !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_mid: got busy=%b done=%b hi=%h lo=%h bus=%h expected all 0",
               dif.busy, dif.done, dif.hi, dif.lo, dif.bus_out);
    end
    check_reg("clear_mid_r1", 4'd1, 32'd0);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    ext_write(4'd1, 32'd7);
    ext_write(4'd2, 32'd5);
    run_op("add_after_clear", 3'd0, 4'd1, 4'd2, 4'd3);
    check_reg("add_after_clear_abs", 4'd3, 32'd12);
  endtask

`ifdef ZERO_REG_EN
  task automatic test_zero_reg();
    ext_write(4'd0, 32'd9);
    check_reg("zero_ext", 4'd0, 32'd0);
    run_op("zero_add", 3'd0, 4'd1, 4'd2, 4'd0);
    check_reg("zero_add_abs", 4'd0, 32'd0);
    run_op("zero_mov", 3'd7, 4'd1, 4'd0, 4'd4);
    check_reg("zero_mov_abs", 4'd4, 32'd0);
  endtask
`endif

  task automatic test_random();
    logic [2:0] o;
    for (int i = 0; i < 16; i++) ext_write(4'(i), $urandom);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) ext_write(4'($urandom_range(0, 15)), $urandom);
      o = 3'($urandom_range(0, 7));
      if (o == 3'd6 && $urandom_range(0, 2) != 0) o = 3'($urandom_range(0, 5));
      run_op("random", o, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) check_reg("random_final", 4'(i), mr(4'(i)));
  endtask

  initial begin
    dif.start = 1'b0; dif.op = 3'd0; dif.ra = 4'd0; dif.rb = 4'd0; dif.rd = 4'd0;
    dif.ext_we = 1'b0; dif.ext_addr = 4'd0; dif.ext_data = 32'd0; dif.dbg_addr = 4'd0;
    clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_basic();
    test_mul();
    test_busy_ignore();
    test_same_cycle();
    test_clear_mid();
`ifdef ZERO_REG_EN
    test_zero_reg();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
